// File: rtl/alu_issue_ctrl.sv
// Execute-stage sequencer for the multi-cycle ALU: accepts one op, holds it on the ALU,
// waits for a fixed latency or the ALU completion flag, then hands the result downstream.
// Optional mul/div abort on a stuck completion flag: define ALU_ISSUE_TIMEOUT_EN.
module alu_issue_ctrl #(
    parameter int unsigned FIXED_LAT      = 1,
    parameter int unsigned COMPLETE_MASK  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_op1,
    input  logic [31:0] in_op2,
    input  logic [4:0]  in_opcode,
    output logic [31:0] alu_operator_1,
    output logic [31:0] alu_operator_2,
    output logic [4:0]  alu_opcode,
    output logic        alu_mdu_en,
    input  logic        alu_complete,
    input  logic [31:0] alu_answer,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_answer,
    output logic        out_error,
    output logic        busy
);

    localparam int unsigned CNT_W = 8;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] FIX_LAST  = CNT_W'(FIXED_LAT - 1);
    localparam logic [CNT_W-1:0] MASK_CNT  = CNT_W'(COMPLETE_MASK);
    localparam logic [CNT_W-1:0] TMO_CNT   = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [4:0]       MDU_FIRST = 5'b00010;
    localparam logic [4:0]       MDU_LAST  = 5'b01001;

`ifdef ALU_ISSUE_TIMEOUT_EN
    localparam logic TMO_EN = 1'b1;
`else
    localparam logic TMO_EN = 1'b0;
`endif

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LAUNCH  = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_HOLD    = 3'd4;

    logic [2:0]       state_q,    state_d;
    logic [31:0]      op1_q,      op1_d;
    logic [31:0]      op2_q,      op2_d;
    logic [4:0]       opc_q,      opc_d;
    logic             mdu_q,      mdu_d;
    logic             mdu_en_q,   mdu_en_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             tmo_q,      tmo_d;
    logic [31:0]      ans_q,      ans_d;
    logic             valid_q,    valid_d;
    logic             err_q,      err_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q,     busy_d;

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        opc_d      = opc_q;
        mdu_d      = mdu_q;
        mdu_en_d   = mdu_en_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        ans_d      = ans_q;
        valid_d    = valid_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    op1_d   = in_op1;
                    op2_d   = in_op2;
                    opc_d   = in_opcode;
                    mdu_d   = (in_opcode >= MDU_FIRST) && (in_opcode <= MDU_LAST);
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                mdu_en_d = mdu_q;
                cnt_d    = '0;
                tmo_d    = 1'b0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                // A completion in the same cycle as the timeout takes priority
                if (!mdu_q) begin
                    if (cnt_q == FIX_LAST) begin
                        state_d = S_CAPTURE;
                    end
                end else if (alu_complete && (cnt_q >= MASK_CNT)) begin
                    state_d = S_CAPTURE;
                end else if (TMO_EN && (cnt_q >= TMO_CNT)) begin
                    tmo_d   = 1'b1;
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                ans_d    = tmo_q ? 32'd0 : alu_answer;
                err_d    = tmo_q;
                valid_d  = 1'b1;
                mdu_en_d = 1'b0;
                state_d  = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op1_q      <= '0;
            op2_q      <= '0;
            opc_q      <= '0;
            mdu_q      <= 1'b0;
            mdu_en_q   <= 1'b0;
            cnt_q      <= '0;
            tmo_q      <= 1'b0;
            ans_q      <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            opc_q      <= opc_d;
            mdu_q      <= mdu_d;
            mdu_en_q   <= mdu_en_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            ans_q      <= ans_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign busy           = busy_q;
    assign alu_operator_1 = op1_q;
    assign alu_operator_2 = op2_q;
    assign alu_opcode     = opc_q;
    assign alu_mdu_en     = mdu_en_q;
    assign out_valid      = valid_q;
    assign out_answer     = ans_q;
    assign out_error      = err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: the bench plays the ALU and the downstream sink,
// predicts answer/latency per op from the protocol rules and checks them in a monitor.
module tb_alu_issue_ctrl;

    localparam int FIXED_LAT      = 1;
    localparam int COMPLETE_MASK  = 2;
    localparam int TIMEOUT_CYCLES = 64;
    localparam int NEVER          = 100000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid, in_ready, out_valid, out_ready, out_error, busy;
    logic        alu_mdu_en, alu_complete;
    logic [31:0] in_op1, in_op2, alu_operator_1, alu_operator_2, alu_answer, out_answer;
    logic [4:0]  in_opcode, alu_opcode;

    alu_issue_ctrl #(
        .FIXED_LAT      (FIXED_LAT),
        .COMPLETE_MASK  (COMPLETE_MASK),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_op1         (in_op1),
        .in_op2         (in_op2),
        .in_opcode      (in_opcode),
        .alu_operator_1 (alu_operator_1),
        .alu_operator_2 (alu_operator_2),
        .alu_opcode     (alu_opcode),
        .alu_mdu_en     (alu_mdu_en),
        .alu_complete   (alu_complete),
        .alu_answer     (alu_answer),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_answer     (out_answer),
        .out_error      (out_error),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  opc;
        logic [31:0] ans;
        bit          mdu;
        bit          err;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          rdy_mode = 0;

    // Behavioural ALU: state of the op it is currently executing
    int          st_acc = -1000;
    int          st_cs = NEVER;
    bit          st_mdu = 1'b0;
    bit          st_stale = 1'b0;
    logic [31:0] st_ans = '0;
    int          rel;

    always @(posedge clk) cyc <= cyc + 1;

    assign rel          = cyc - st_acc;
    assign alu_complete = st_mdu && ((rel >= st_cs) || (st_stale && rel >= 0 && rel <= 2));
    assign alu_answer   = (!st_mdu || rel >= st_cs) ? st_ans : 32'hDEAD_BEEF;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] opc);
        if (opc == 5'd0)                    return a + b;
        else if (opc >= 5'd2 && opc <= 5'd5) return a * b;
        else if (opc >= 5'd6 && opc <= 5'd9) return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
        else                                return a ^ b;
    endfunction

    // Expected result and accept-to-out_valid latency in cycles
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] opc, input int cs);
        exp_t e;
        int   w;
        e.a   = a;
        e.b   = b;
        e.opc = opc;
        e.mdu = (opc >= 5'd2) && (opc <= 5'd9);
        e.ans = alu_fn(a, b, opc);
        e.err = 1'b0;
        e.acc = 0;
        if (!e.mdu) begin
            e.lat = 2 + FIXED_LAT;
        end else begin
            // WAIT cycle (0-based) in which the completion is honoured
            w = (cs - 1 > COMPLETE_MASK) ? cs - 1 : COMPLETE_MASK;
`ifdef ALU_ISSUE_TIMEOUT_EN
            if (w > TIMEOUT_CYCLES) begin
                w     = TIMEOUT_CYCLES;
                e.err = 1'b1;
                e.ans = 32'd0;
            end
`endif
            e.lat = 3 + w;
        end
        return e;
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] opc,
                         input int cs, input bit stale, input bit keep, output int acc);
        exp_t e;
        int   g;
        bit   ok;
        g  = 0;
        ok = 1'b0;
        acc = -1;
        in_valid  = 1'b1;
        in_op1    = a;
        in_op2    = b;
        in_opcode = opc;
        while (!ok && g < 400) begin
            @(negedge clk);
            if (in_ready && !rst) ok = 1'b1;
            else g++;
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_wait: in_ready never seen, expected 1");
            in_valid = 1'b0;
            return;
        end
        e        = model(a, b, opc, cs);
        e.acc    = cyc + 1;
        acc      = e.acc;
        st_acc   = e.acc;
        st_cs    = cs;
        st_mdu   = e.mdu;
        st_stale = stale;
        st_ans   = alu_fn(a, b, opc);
        q.push_back(e);
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (q.size() != 0 && g < 600) begin
            @(negedge clk);
            g++;
        end
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d results outstanding, expected 0", q.size());
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Downstream ready generator
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: checks every presented result against the scoreboard
    initial begin
        bit seen;
        bit pend_idle;
        int n;
        seen      = 1'b0;
        pend_idle = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen      = 1'b0;
                pend_idle = 1'b0;
                continue;
            end
            if (pend_idle) begin
                pend_idle = 1'b0;
                chk("idle_busy", 32'(busy), 32'd0);
                chk("idle_in_ready", 32'(in_ready), 32'd1);
                chk("idle_out_valid", 32'(out_valid), 32'd0);
                chk("idle_out_error", 32'(out_error), 32'd0);
            end
            if (q.size() != 0 && !out_valid) begin
                n = cyc - q[0].acc;
                if (n == 1) begin
                    chk("wait_mdu_en", 32'(alu_mdu_en), 32'(q[0].mdu));
                    chk("wait_in_ready", 32'(in_ready), 32'd0);
                end
                if (n == q[0].lat - 1) chk("capture_mdu_en", 32'(alu_mdu_en), 32'(q[0].mdu));
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_out: out_valid=1 answer %h, expected no result", out_answer);
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        chk("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
                        chk("answer", out_answer, q[0].ans);
                        chk("alu_op1", alu_operator_1, q[0].a);
                        chk("alu_op2", alu_operator_2, q[0].b);
                        chk("alu_opcode", 32'(alu_opcode), 32'(q[0].opc));
                        chk("hold_mdu_en", 32'(alu_mdu_en), 32'd0);
                    end else begin
                        chk("hold_answer", out_answer, q[0].ans);
                    end
                    chk("error", 32'(out_error), 32'(q[0].err));
                    chk("hold_in_ready", 32'(in_ready), 32'd0);
                    chk("hold_busy", 32'(busy), 32'd1);
                    if (out_ready) begin
                        void'(q.pop_front());
                        seen      = 1'b0;
                        pend_idle = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        int acc1;
        int acc2;
        int g;
        in_valid  = 1'b0;
        in_op1    = '0;
        in_op2    = '0;
        in_opcode = '0;

        #3 rst = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_error", 32'(out_error), 32'd0);
        chk("rst_mdu_en", 32'(alu_mdu_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_answer", out_answer, 32'd0);
        chk("rst_alu_op1", alu_operator_1, 32'd0);
        chk("rst_alu_op2", alu_operator_2, 32'd0);
        chk("rst_alu_opcode", 32'(alu_opcode), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // ADD 5+7 with downstream always ready
        rdy_mode = 0;
        issue(32'd5, 32'd7, 5'd0, 0, 1'b0, 1'b0, acc1);
        wait_idle();

        // MUL 3*-2 with a stale completion at launch and the real one 34 cycles in
        issue(32'd3, 32'hFFFF_FFFE, 5'd2, 34, 1'b1, 1'b0, acc1);
        wait_idle();

        // Backpressure: result held 10 cycles while upstream pokes at the controller
        rdy_mode = 2;
        issue(32'd100, 32'd23, 5'd0, 0, 1'b0, 1'b0, acc1);
        g = 0;
        while (!out_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        repeat (10) begin
            @(posedge clk);
            #1;
            in_valid  = 1'($urandom_range(0, 1));
            in_op1    = $urandom();
            in_op2    = $urandom();
            in_opcode = 5'($urandom_range(0, 31));
        end
        in_valid = 1'b0;
        rdy_mode = 0;
        wait_idle();
        chk("bp_op1_kept", alu_operator_1, 32'd100);
        chk("bp_op2_kept", alu_operator_2, 32'd23);

        // Reset while a DIV sits in WAIT: aborted silently
        issue(32'd100, 32'd7, 5'd6, NEVER, 1'b0, 1'b0, acc1);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_mdu_en", 32'(alu_mdu_en), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        q.delete();
        st_mdu = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_quiet_valid", 32'(out_valid), 32'd0);
        chk("abort_quiet_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // Back-to-back ADDs with in_valid held high
        issue(32'd1, 32'd2, 5'd0, 0, 1'b0, 1'b1, acc1);
        issue(32'd10, 32'd20, 5'd0, 0, 1'b0, 1'b0, acc2);
        chk("b2b_spacing", 32'(acc2 - acc1), 32'(FIXED_LAT + 4));
        wait_idle();

`ifdef ALU_ISSUE_TIMEOUT_EN
        // DIV with completion stuck low aborts; completion on the timeout cycle still wins
        issue(32'd50, 32'd5, 5'd7, NEVER, 1'b0, 1'b0, acc1);
        wait_idle();
        issue(32'd50, 32'd5, 5'd8, TIMEOUT_CYCLES + 1, 1'b0, 1'b0, acc1);
        wait_idle();
`endif

        // Randomised mix with random downstream backpressure
        rdy_mode = 1;
        for (int i = 0; i < 30; i++) begin
            issue($urandom(), $urandom(), 5'($urandom_range(0, 31)),
                  int'($urandom_range(1, 40)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), acc1);
        end
        in_valid = 1'b0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
